// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller/sequencer: opcodes, control-word
// bit positions and the fixed control words emitted in each T-state.
package sap_pkg;

  localparam int OP_W   = 4;
  localparam int CON_W  = 12;
  localparam int RING_W = 6;

  // Opcodes (instruction register upper nibble)
  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Control-word bit positions, MSB first:
  // {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
  localparam int CON_CP     = 11;
  localparam int CON_EP     = 10;
  localparam int CON_LM_BAR = 9;
  localparam int CON_CE_BAR = 8;
  localparam int CON_LI_BAR = 7;
  localparam int CON_EI_BAR = 6;
  localparam int CON_LA_BAR = 5;
  localparam int CON_EA     = 4;
  localparam int CON_SU     = 3;
  localparam int CON_EU     = 2;
  localparam int CON_LB_BAR = 1;
  localparam int CON_LO_BAR = 0;

  // Idle word: every active-low strobe high, every active-high strobe low
  localparam logic [CON_W-1:0] CW_NOP    = 12'h3E3;

  // Fetch cycle
  localparam logic [CON_W-1:0] CW_T1     = 12'h5E3;
  localparam logic [CON_W-1:0] CW_T2     = 12'hBE3;
  localparam logic [CON_W-1:0] CW_T3     = 12'h263;

  // Execute cycle
  localparam logic [CON_W-1:0] CW_LDA_T4 = 12'h1A3;
  localparam logic [CON_W-1:0] CW_LDA_T5 = 12'h2C3;
  localparam logic [CON_W-1:0] CW_LDA_T6 = 12'h3E3;
  localparam logic [CON_W-1:0] CW_ADD_T4 = 12'h1A3;
  localparam logic [CON_W-1:0] CW_ADD_T5 = 12'h2E1;
  localparam logic [CON_W-1:0] CW_ADD_T6 = 12'h3C7;
  localparam logic [CON_W-1:0] CW_SUB_T4 = 12'h1A3;
  localparam logic [CON_W-1:0] CW_SUB_T5 = 12'h2E1;
  localparam logic [CON_W-1:0] CW_SUB_T6 = 12'h3CF;
  localparam logic [CON_W-1:0] CW_OUT_T4 = 12'h3F2;

  // One-hot ring states, bit0 = T1
  localparam logic [RING_W-1:0] ST_T1 = 6'b000001;
  localparam logic [RING_W-1:0] ST_T2 = 6'b000010;
  localparam logic [RING_W-1:0] ST_T3 = 6'b000100;
  localparam logic [RING_W-1:0] ST_T4 = 6'b001000;
  localparam logic [RING_W-1:0] ST_T5 = 6'b010000;
  localparam logic [RING_W-1:0] ST_T6 = 6'b100000;

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// Controller-side bus bundle: opcode in, control word / halt / ring state out.
interface sap_controller_sequencer_if #(
  parameter int OP_WIDTH = 4
) ();
  logic [OP_WIDTH-1:0] opcode;
  logic [11:0]         con;
  logic                hlt;
  logic [5:0]          t_state;

  modport master (input opcode, output con, output hlt, output t_state);
  modport slave  (output opcode, input con, input hlt, input t_state);
endinterface

// File: rtl/sap_ring_counter.sv
// Six-state one-hot ring counter. Any non-one-hot value falls back to T1 on
// the next edge so an upset cannot leave the sequencer stuck.
module sap_ring_counter
  import sap_pkg::*;
#(
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_hold,
  output logic [T_STATES-1:0] o_ring
);

  logic [T_STATES-1:0] r_ring;
  logic                w_legal;

  // Legal means exactly one bit set
  always_comb begin
    w_legal = $onehot(r_ring);
  end

  // Advance, hold, or recover the ring on every rising edge
  always_ff @(posedge clk) begin
    if (rst || !w_legal) begin
      r_ring <= T_STATES'(1);
    end else if (!i_hold) begin
      r_ring <= {r_ring[T_STATES-2:0], r_ring[T_STATES-1]};
    end
  end

  assign o_ring = r_ring;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP bus-master controller: one-hot T1..T6 ring plus combinational decode
// of (ring, opcode, halted) into the 12-bit strobe word, and a sticky halt.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int OP_WIDTH = 4,
  parameter int T_STATES = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  sap_controller_sequencer_if.master bus
);

  logic [T_STATES-1:0] w_ring;
  logic [OP_WIDTH-1:0] w_opcode;
  logic                w_hlt_now;
  logic                w_hold;
  logic [CON_W-1:0]    w_con;
  logic                r_halted;

  assign w_opcode  = bus.opcode;
  // HLT decoded in T4 freezes the ring in T4 immediately, then the flop keeps it there
  assign w_hlt_now = (w_ring == ST_T4) && (w_opcode == OP_HLT);
  assign w_hold    = r_halted || w_hlt_now;

  sap_ring_counter #(
    .T_STATES (T_STATES)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_hold (w_hold),
    .o_ring (w_ring)
  );

  // Sticky halt: set at the end of T4 of HLT, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_hlt_now) begin
      r_halted <= 1'b1;
    end
  end

  // Decode ring state (and opcode during execute) into the control word
  always_comb begin
    w_con = CW_NOP;
    if (!rst && !r_halted) begin
      case (w_ring)
        ST_T1: w_con = CW_T1;
        ST_T2: w_con = CW_T2;
        ST_T3: w_con = CW_T3;
        ST_T4: begin
          case (w_opcode)
            OP_LDA:  w_con = CW_LDA_T4;
            OP_ADD:  w_con = CW_ADD_T4;
            OP_SUB:  w_con = CW_SUB_T4;
            OP_OUT:  w_con = CW_OUT_T4;
            default: w_con = CW_NOP;
          endcase
        end
        ST_T5: begin
          case (w_opcode)
            OP_LDA:  w_con = CW_LDA_T5;
            OP_ADD:  w_con = CW_ADD_T5;
            OP_SUB:  w_con = CW_SUB_T5;
            default: w_con = CW_NOP;
          endcase
        end
        ST_T6: begin
          case (w_opcode)
            OP_LDA:  w_con = CW_LDA_T6;
            OP_ADD:  w_con = CW_ADD_T6;
            OP_SUB:  w_con = CW_SUB_T6;
            default: w_con = CW_NOP;
          endcase
        end
        default: w_con = CW_NOP;
      endcase
    end
  end

  assign bus.con     = w_con;
  assign bus.hlt     = r_halted && !rst;
  assign bus.t_state = w_ring;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed bench for the SAP controller/sequencer.
module tb_sap_controller_sequencer;
  import sap_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sap_controller_sequencer_if #(.OP_WIDTH(4)) u_if ();

  sap_controller_sequencer #(
    .OP_WIDTH (4),
    .T_STATES (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.opcode = OP_LDA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (u_if.con !== 12'h3E3) begin
        errors++;
        $display("FAIL reset_con cyc%0d got %h want 3e3", i, u_if.con);
      end
      checks++;
      if (u_if.hlt !== 1'b0) begin
        errors++;
        $display("FAIL reset_hlt cyc%0d got %b want 0", i, u_if.hlt);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (u_if.con !== 12'h5E3 || u_if.t_state !== 6'h01) begin
      errors++;
      $display("FAIL fetch_t1 got con=%h t=%h want 5e3/01", u_if.con, u_if.t_state);
    end
    tick();
    checks++;
    if (u_if.con !== 12'hBE3 || u_if.t_state !== 6'h02) begin
      errors++;
      $display("FAIL fetch_t2 got con=%h t=%h want be3/02", u_if.con, u_if.t_state);
    end
    tick();
    checks++;
    if (u_if.con !== 12'h263 || u_if.t_state !== 6'h04) begin
      errors++;
      $display("FAIL fetch_t3 got con=%h t=%h want 263/04", u_if.con, u_if.t_state);
    end
  endtask

  // Entered in T3; leaves the ring in T1
  task automatic test_lda();
    logic [11:0] exp [3];
    exp[0] = 12'h1A3; exp[1] = 12'h2C3; exp[2] = 12'h3E3;
    u_if.opcode = OP_LDA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (u_if.con !== exp[i] || u_if.t_state !== (6'h08 << i)) begin
        errors++;
        $display("FAIL lda_t%0d got con=%h t=%h want %h/%h", i + 4, u_if.con, u_if.t_state, exp[i], 6'h08 << i);
      end
    end
    tick();
    checks++;
    if (u_if.con !== 12'h5E3 || u_if.t_state !== 6'h01) begin
      errors++;
      $display("FAIL lda_wrap got con=%h t=%h want 5e3/01", u_if.con, u_if.t_state);
    end
  endtask

  // Entered in T1; opcode churn in fetch must not disturb fetch words
  task automatic test_add_sub();
    logic [3:0]  ops [2];
    logic [11:0] t6  [2];
    ops[0] = OP_ADD; ops[1] = OP_SUB;
    t6[0]  = 12'h3C7; t6[1] = 12'h3CF;
    for (int k = 0; k < 2; k++) begin
      u_if.opcode = 4'h5;
      #1;
      checks++;
      if (u_if.con !== 12'h5E3) begin
        errors++;
        $display("FAIL fetch_ignore_t1 op%0d got %h want 5e3", k, u_if.con);
      end
      tick();
      u_if.opcode = OP_HLT;
      #1;
      checks++;
      if (u_if.con !== 12'hBE3) begin
        errors++;
        $display("FAIL fetch_ignore_t2 op%0d got %h want be3", k, u_if.con);
      end
      tick();
      u_if.opcode = ops[k];
      #1;
      checks++;
      if (u_if.con !== 12'h263) begin
        errors++;
        $display("FAIL fetch_ignore_t3 op%0d got %h want 263", k, u_if.con);
      end
      tick();
      checks++;
      if (u_if.con !== 12'h1A3) begin
        errors++;
        $display("FAIL alu_t4 op%0d got %h want 1a3", k, u_if.con);
      end
      tick();
      checks++;
      if (u_if.con !== 12'h2E1) begin
        errors++;
        $display("FAIL alu_t5 op%0d got %h want 2e1", k, u_if.con);
      end
      tick();
      checks++;
      if (u_if.con !== t6[k]) begin
        errors++;
        $display("FAIL alu_t6 op%0d got %h want %h", k, u_if.con, t6[k]);
      end
      tick();
    end
  endtask

  // Entered in T1
  task automatic test_out();
    logic [11:0] exp [3];
    exp[0] = 12'h3F2; exp[1] = 12'h3E3; exp[2] = 12'h3E3;
    u_if.opcode = OP_OUT;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (u_if.con !== exp[i]) begin
        errors++;
        $display("FAIL out_t%0d got %h want %h", i + 4, u_if.con, exp[i]);
      end
    end
    tick();
  endtask

  // Entered in T1; leaves ring in T1 after a reset
  task automatic test_halt();
    u_if.opcode = OP_HLT;
    tick(); tick(); tick();
    checks++;
    if (u_if.con !== 12'h3E3 || u_if.hlt !== 1'b0 || u_if.t_state !== 6'h08) begin
      errors++;
      $display("FAIL hlt_t4 got con=%h hlt=%b t=%h want 3e3/0/08", u_if.con, u_if.hlt, u_if.t_state);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (u_if.con !== 12'h3E3 || u_if.hlt !== 1'b1 || u_if.t_state !== 6'h08) begin
        errors++;
        $display("FAIL halted cyc%0d got con=%h hlt=%b t=%h want 3e3/1/08", i, u_if.con, u_if.hlt, u_if.t_state);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (u_if.con !== 12'h3E3 || u_if.hlt !== 1'b0) begin
      errors++;
      $display("FAIL hlt_rst got con=%h hlt=%b want 3e3/0", u_if.con, u_if.hlt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (u_if.con !== 12'h5E3 || u_if.t_state !== 6'h01 || u_if.hlt !== 1'b0) begin
      errors++;
      $display("FAIL hlt_release got con=%h t=%h hlt=%b want 5e3/01/0", u_if.con, u_if.t_state, u_if.hlt);
    end
  endtask

  // Entered in T1
  task automatic test_rst_mid();
    u_if.opcode = OP_ADD;
    tick(); tick(); tick(); tick();
    checks++;
    if (u_if.con !== 12'h2E1 || u_if.t_state !== 6'h10) begin
      errors++;
      $display("FAIL mid_t5 got con=%h t=%h want 2e1/10", u_if.con, u_if.t_state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (u_if.con !== 12'h5E3 || u_if.t_state !== 6'h01) begin
      errors++;
      $display("FAIL mid_restart got con=%h t=%h want 5e3/01", u_if.con, u_if.t_state);
    end
    u_if.opcode = 4'h7;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (u_if.con !== 12'h3E3) begin
        errors++;
        $display("FAIL nop_t%0d got %h want 3e3", i + 4, u_if.con);
      end
    end
    tick();
    checks++;
    if (u_if.con !== 12'h5E3 || u_if.t_state !== 6'h01) begin
      errors++;
      $display("FAIL nop_wrap got con=%h t=%h want 5e3/01", u_if.con, u_if.t_state);
    end
  endtask

  // Random opcode per instruction; structural invariants every cycle
  task automatic test_invariants();
    int drivers;
    for (int i = 0; i < 300; i++) begin
      if (u_if.t_state == 6'h04) u_if.opcode = 4'($urandom_range(0, 15));
      if (u_if.hlt === 1'b1 && ($urandom_range(0, 3) == 0)) rst = 1'b1;
      #1;
      drivers = int'(u_if.con[CON_EP]) + int'(!u_if.con[CON_CE_BAR]) + int'(!u_if.con[CON_EI_BAR])
              + int'(u_if.con[CON_EA]) + int'(u_if.con[CON_EU]);
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL bus_contention cyc%0d got %0d drivers con=%h want <=1", i, drivers, u_if.con);
      end
      checks++;
      if (u_if.con[CON_SU] && !u_if.con[CON_EU]) begin
        errors++;
        $display("FAIL su_without_eu cyc%0d con=%h", i, u_if.con);
      end
      checks++;
      if (!$onehot(u_if.t_state)) begin
        errors++;
        $display("FAIL ring_onehot cyc%0d got t=%h", i, u_if.t_state);
      end
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if.opcode = 4'h0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out();
    test_halt();
    test_rst_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
